// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 Laplacian edge-detection block.
package conv_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned ACC_W_DEF = 12;
  localparam int          CLAMP_MAX = 255;

  typedef logic [1:0] idx_t;

  localparam int signed KERNEL [3][3] = '{
    '{-1, -1, -1},
    '{-1,  8, -1},
    '{-1, -1, -1}
  };

endpackage

// File: rtl/conv_window.sv
// 3x3 pixel window store: address decode, nine pixel registers and the loaded mask.
module conv_window
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  idx_t                  row_i,
  input  idx_t                  col_i,
  input  logic [PIX_W-1:0]      data_i,
  output logic [8:0][PIX_W-1:0] pix_o,
  output logic                  full_o
);

  logic [8:0][PIX_W-1:0] pix_q, pix_d;
  logic [8:0]            loaded_q, loaded_d;
  logic [3:0]            idx;

  always_comb begin
    pix_d    = pix_q;
    loaded_d = loaded_q;
    idx      = {2'b00, row_i} * 4'd3 + {2'b00, col_i};
    // Row or column 3 is outside the window; such writes are dropped entirely.
    if (we_i && (row_i != 2'd3) && (col_i != 2'd3)) begin
      pix_d[idx]    = data_i;
      loaded_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_q    <= '0;
      loaded_q <= '0;
    end else begin
      pix_q    <= pix_d;
      loaded_q <= loaded_d;
    end
  end

  assign pix_o  = pix_q;
  assign full_o = &loaded_q;

endmodule

// File: rtl/conv.sv
// 3x3 Laplacian convolution with registered, clamped output.
// Define CONV_ABS_EN to report negative sums by magnitude instead of clamping to 0.
module conv
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic [1:0]       row_in,
  input  logic [1:0]       col_in,
  input  logic [PIX_W-1:0] data,
  output logic [PIX_W-1:0] out,
  output logic             out_valid
);

  logic [8:0][PIX_W-1:0]   pix;
  logic                    full;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] mag;
  logic [PIX_W-1:0]        out_d, out_q;
  logic                    valid_q;

  conv_window #(
    .PIX_W (PIX_W)
  ) u_window (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (data_in),
    .row_i  (row_in),
    .col_i  (col_in),
    .data_i (data),
    .pix_o  (pix),
    .full_o (full)
  );

  always_comb begin
    acc = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        acc = acc + ACC_W'(KERNEL[r][c])
                  * $signed({{(ACC_W-PIX_W){1'b0}}, pix[r*3+c]});
      end
    end
  end

  always_comb begin
`ifdef CONV_ABS_EN
    mag = acc[ACC_W-1] ? -acc : acc;
`else
    mag = acc[ACC_W-1] ? '0 : acc;
`endif
    out_d = (mag > ACC_W'(CLAMP_MAX)) ? PIX_W'(CLAMP_MAX) : mag[PIX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= full;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_conv.sv
// Directed self-checking bench for conv.
module tb_conv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic [1:0] row_in = '0;
  logic [1:0] col_in = '0;
  logic [7:0] data = '0;
  logic [7:0] dout;
  logic       out_valid;

  int checks = 0;
  int failures = 0;

  conv dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .row_in    (row_in),
    .col_in    (col_in),
    .data      (data),
    .out       (dout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one write; returns at the falling edge after the capturing edge.
  task automatic wr(input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    data_in = 1'b1;
    row_in  = r;
    col_in  = c;
    data    = d;
    @(negedge clk);
    data_in = 1'b0;
  endtask

  task automatic fill(input logic [7:0] centre, input logic [7:0] others);
    for (int unsigned i = 0; i < 9; i++)
      wr(2'(i / 3), 2'(i % 3), (i == 4) ? centre : others);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_out", 32'(dout), 0);
    check("reset_valid", 32'(out_valid), 0);
    do_reset();

    // 1..9 row-major: valid rises one cycle after the ninth write
    for (int unsigned i = 0; i < 9; i++)
      wr(2'(i / 3), 2'(i % 3), 8'(i + 1));
    check("seq_valid_early", 32'(out_valid), 0);
    @(negedge clk);
    check("seq_valid", 32'(out_valid), 1);
    check("seq_out", 32'(dout), 0);

    // Centre 10, others 1 -> 80-8
    fill(8'd10, 8'd1);
    @(negedge clk);
    check("c10_out", 32'(dout), 72);
    check("c10_valid", 32'(out_valid), 1);

    // Centre 255 saturates from 2040
    fill(8'd255, 8'd0);
    @(negedge clk);
    check("sat_out", 32'(dout), 255);

    // Corner 50 only -> sum -50
    fill(8'd0, 8'd0);
    wr(2'd0, 2'd0, 8'd50);
    @(negedge clk);
`ifdef CONV_ABS_EN
    check("corner_out", 32'(dout), 50);
`else
    check("corner_out", 32'(dout), 0);
`endif

    // Reset mid-load discards partial data
    do_reset();
    for (int unsigned i = 0; i < 5; i++)
      wr(2'(i / 3), 2'(i % 3), 8'd7);
    @(negedge clk);
    check("part_out", 32'(dout), 28);
    check("part_valid", 32'(out_valid), 0);
    #2 rst = 1'b1;
    #1;
    check("async_out", 32'(dout), 0);
    check("async_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 5; i < 9; i++)
      wr(2'(i / 3), 2'(i % 3), 8'd2);
    @(negedge clk);
    check("after_rst_valid", 32'(out_valid), 0);
    check("after_rst_out", 32'(dout), 0);

    // Out-of-range and repeated writes must not advance validity
    do_reset();
    wr(2'd3, 2'd1, 8'd99);
    wr(2'd1, 2'd3, 8'd99);
    wr(2'd0, 2'd0, 8'd0);
    wr(2'd0, 2'd0, 8'd0);
    for (int unsigned i = 0; i < 8; i++)
      wr(2'(i / 3), 2'(i % 3), 8'd0);
    @(negedge clk);
    check("oob_valid_8", 32'(out_valid), 0);
    wr(2'd2, 2'd2, 8'd0);
    @(negedge clk);
    check("oob_valid_9", 32'(out_valid), 1);
    wr(2'd3, 2'd0, 8'd99);
    wr(2'd1, 2'd3, 8'd99);
    @(negedge clk);
    check("oob_out", 32'(dout), 0);

    // Overwrite centre with 3 in a full zero window
    wr(2'd1, 2'd1, 8'd3);
    check("ovr_latency", 32'(dout), 0);
    @(negedge clk);
    check("ovr_out", 32'(dout), 24);
    check("ovr_valid", 32'(out_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
